// File: rtl/data_mem_ctrl_if.sv
// Data-memory bus between the load/store sequencer (master) and the memory (slave).
// One beat: master raises mem_req with address/enables/data held steady until mem_ack.
interface data_mem_ctrl_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer: runs one RISC-V memory access over a 32-bit req/ack bus,
// splitting ld/sd into two beats, and returns extended load data in a 64-bit MDR
// with a one-cycle done pulse (err flags misalign, illegal funct3 or bus timeout).
module data_mem_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          DMemOp,
   input  logic [2:0]    funct3,
   input  logic [63:0]   addr,
   input  logic [63:0]   wdata,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [63:0]   mdr,
   data_mem_ctrl_if.master bus
);

   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, FIN} state_t;

   localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   state_t      state;
   logic        is_store;
   logic [2:0]  size_f3;
   logic [1:0]  offset;
   logic [31:0] wdata_hi;
   logic [31:0] lo_word;
   logic [31:0] tmo_cnt;
   logic        req, we;
   logic [31:0] baddr;
   logic [3:0]  be;
   logic [31:0] bwdata;
   logic        bad_req;
   logic [3:0]  be_init;
   logic        tmo_hit;

   assign bus.mem_req   = req;
   assign bus.mem_we    = we;
   assign bus.mem_addr  = baddr;
   assign bus.mem_be    = be;
   assign bus.mem_wdata = bwdata;

   // Pick the addressed lane out of a bus word and sign/zero-extend it per funct3.
   function automatic logic [63:0] extract_load(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
      logic [31:0]        lane;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      logic signed [31:0] sw;
      lane = word >> {off, 3'b000};
      sb   = lane[7:0];
      sh   = lane[15:0];
      sw   = lane;
      case (f3)
         3'b000:  extract_load = 64'(sb);
         3'b001:  extract_load = 64'(sh);
         3'b010:  extract_load = 64'(sw);
         3'b100:  extract_load = {56'd0, lane[7:0]};
         3'b101:  extract_load = {48'd0, lane[15:0]};
         default: extract_load = {32'd0, lane};
      endcase
   endfunction

   // Decode the incoming request: legality, alignment and first-beat byte enables.
   always_comb begin
      bad_req = (funct3 == 3'b111) || (DMemOp && funct3[2]);
      be_init = 4'b1111;
      case (funct3[1:0])
         2'b00: be_init = 4'b0001 << addr[1:0];
         2'b01: begin
            be_init = 4'b0011 << addr[1:0];
            if (addr[0]) bad_req = 1'b1;
         end
         2'b10: if (addr[1:0] != 2'b00) bad_req = 1'b1;
         default: if (addr[2:0] != 3'b000) bad_req = 1'b1;
      endcase
   end

   assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

   // Request payload that only feeds data paths; no reset needed.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         offset   <= addr[1:0];
         wdata_hi <= wdata[63:32];
      end
      if (state == BEAT0 && req && bus.mem_ack) lo_word <= bus.mem_rdata;
   end

   // Access sequencer with registered status and bus outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         is_store <= 1'b0;
         size_f3  <= 3'b000;
         tmo_cnt  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         mdr      <= '0;
         req      <= 1'b0;
         we       <= 1'b0;
         baddr    <= '0;
         be       <= '0;
         bwdata   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  is_store <= DMemOp;
                  size_f3  <= funct3;
                  busy     <= 1'b1;
                  tmo_cnt  <= '0;
                  if (bad_req) begin
                     state <= FIN;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state  <= BEAT0;
                     err    <= 1'b0;
                     req    <= 1'b1;
                     we     <= DMemOp;
                     baddr  <= {addr[31:2], 2'b00};
                     be     <= be_init;
                     bwdata <= wdata[31:0] << {addr[1:0], 3'b000};
                  end
               end
            end
            BEAT0: begin
               if (bus.mem_ack) begin
                  req <= 1'b0;
                  if (size_f3[1:0] == 2'b11) begin
                     state   <= BEAT1;
                     baddr   <= baddr + 32'd4;
                     be      <= 4'b1111;
                     bwdata  <= wdata_hi;
                     tmo_cnt <= '0;
                  end else begin
                     state <= FIN;
                     done  <= 1'b1;
                     if (!is_store) mdr <= extract_load(size_f3, offset, bus.mem_rdata);
                  end
               end else if (tmo_hit) begin
                  req   <= 1'b0;
                  state <= FIN;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            BEAT1: begin
               // First BEAT1 cycle is the mandatory idle gap between beats.
               if (!req) begin
                  req     <= 1'b1;
                  tmo_cnt <= '0;
               end else if (bus.mem_ack) begin
                  req   <= 1'b0;
                  state <= FIN;
                  done  <= 1'b1;
                  if (!is_store) mdr <= {bus.mem_rdata, lo_word};
               end else if (tmo_hit) begin
                  req   <= 1'b0;
                  state <= FIN;
                  done  <= 1'b1;
                  err   <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 32'd1;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: per-transaction timeline model plus directed literal cases.
module tb_data_mem_ctrl;
   localparam int T = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        DMemOp = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [63:0] addr = '0;
   logic [63:0] wdata = '0;
   logic        busy, done, err;
   logic [63:0] mdr;

   data_mem_ctrl_if bus();

   data_mem_ctrl #(.TIMEOUT(T)) dut (
      .clk(clk), .reset(reset), .start(start), .DMemOp(DMemOp), .funct3(funct3),
      .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .mdr(mdr),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Expected per-cycle timeline of the current transaction (index = cycles after start).
   logic        exp_req  [0:63];
   logic        exp_done [0:63];
   logic        exp_busy [0:63];
   logic        exp_err  [0:63];
   logic [63:0] exp_mdr  [0:63];
   int          exp_beat [0:63];
   logic [31:0] bx_addr [0:1];
   logic [31:0] bx_wd   [0:1];
   logic [3:0]  bx_be   [0:1];
   logic        bx_we;
   int          cur_k = 0;
   bit          chk_on = 1'b0;

   logic        prev_err = 1'b0;
   logic [63:0] prev_mdr = '0;

   int          done_k, req_cnt;
   logic        snap_req0, snap_we0;
   logic [31:0] snap_addr0, snap_wd0, snap_addr1;
   logic [3:0]  snap_be0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
   endtask

   // Single compare process: DUT outputs against the model timeline every cycle.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("busy", {63'd0, busy}, {63'd0, exp_busy[cur_k]});
         chk("done", {63'd0, done}, {63'd0, exp_done[cur_k]});
         chk("err", {63'd0, err}, {63'd0, exp_err[cur_k]});
         chk("mdr", mdr, exp_mdr[cur_k]);
         chk("mem_req", {63'd0, bus.mem_req}, {63'd0, exp_req[cur_k]});
         if (exp_req[cur_k]) begin
            chk("mem_addr", {32'd0, bus.mem_addr}, {32'd0, bx_addr[exp_beat[cur_k]]});
            chk("mem_be", {60'd0, bus.mem_be}, {60'd0, bx_be[exp_beat[cur_k]]});
            chk("mem_wdata", {32'd0, bus.mem_wdata}, {32'd0, bx_wd[exp_beat[cur_k]]});
            chk("mem_we", {63'd0, bus.mem_we}, {63'd0, bx_we});
         end
      end
   end

   // One access: build the expected timeline from the access rules, then drive it.
   // d0/d1 = req cycles without ack before the ack (>= T means never acked).
   task automatic run_txn(input bit op, input bit [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input int d0, input int d1,
                          input logic [31:0] r0, input logic [31:0] r1, input bit stray);
      bit          bad, tmo;
      int          nb, off, fin, a0, a1, s1;
      logic [63:0] raw, mask, new_mdr;
      bad = (f3 == 3'b111) || (op && f3[2]);
      nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 8;
      off = int'(a[1:0]);
      if ((int'(a[2:0]) % nb) != 0) bad = 1'b1;
      tmo = 1'b0; a0 = -1; a1 = -1; s1 = -1; fin = 1;
      for (int k = 0; k < 64; k++) begin
         exp_req[k] = 1'b0; exp_done[k] = 1'b0; exp_beat[k] = 0;
      end
      if (!bad) begin
         if (d0 < T) begin
            for (int k = 1; k <= d0 + 1; k++) exp_req[k] = 1'b1;
            a0 = d0 + 1; fin = d0 + 2;
         end else begin
            for (int k = 1; k <= T; k++) exp_req[k] = 1'b1;
            tmo = 1'b1; fin = T + 1;
         end
         if (nb == 8 && !tmo) begin
            s1 = a0 + 2;
            if (d1 < T) begin
               for (int k = s1; k <= s1 + d1; k++) begin exp_req[k] = 1'b1; exp_beat[k] = 1; end
               a1 = s1 + d1; fin = a1 + 1;
            end else begin
               for (int k = s1; k < s1 + T; k++) begin exp_req[k] = 1'b1; exp_beat[k] = 1; end
               tmo = 1'b1; fin = s1 + T;
            end
         end
      end
      raw = {r1, r0} >> (8 * off);
      if (nb < 8) begin
         mask = (64'd1 << (8 * nb)) - 64'd1;
         raw  = raw & mask;
         if (!f3[2] && raw[8 * nb - 1]) raw = raw | ~mask;
      end
      new_mdr = (!op && !bad && !tmo) ? raw : prev_mdr;
      exp_done[fin] = 1'b1;
      for (int k = 0; k < 64; k++) begin
         exp_busy[k] = (k >= 1) && (k <= fin);
         exp_err[k]  = (k == 0) ? prev_err : (k >= fin) ? (bad || tmo) : 1'b0;
         exp_mdr[k]  = (k >= fin) ? new_mdr : prev_mdr;
      end
      bx_addr[0] = {a[31:2], 2'b00};
      bx_addr[1] = bx_addr[0] + 32'd4;
      bx_wd[1]   = wd[63:32];
      bx_be[1]   = 4'b1111;
      bx_we      = op;
      for (int i = 0; i < 4; i++) begin
         bx_be[0][i]       = (nb >= 4) || (i >= off && i < off + nb);
         bx_wd[0][8*i +: 8] = (i >= off) ? wd[8*(i-off) +: 8] : 8'h00;
      end

      // cycle 0: present the request
      start = 1'b1; DMemOp = op; funct3 = f3; addr = a; wdata = wd;
      bus.mem_ack = ($urandom % 3 == 0); bus.mem_rdata = $urandom;
      cur_k = 0; chk_on = 1'b1;
      done_k = -1; req_cnt = 0;
      for (int k = 1; k <= fin; k++) begin
         @(posedge clk); #1;
         cur_k = k;
         if (stray) begin
            start = $urandom % 2; DMemOp = $urandom % 2; funct3 = 3'($urandom);
            addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
         end else begin
            start = 1'b0;
         end
         bus.mem_ack   = (k == a0) || (k == a1) || (!exp_req[k] && ($urandom % 3 == 0));
         bus.mem_rdata = (k == a0) ? r0 : (k == a1) ? r1 : $urandom;
         if (done && done_k < 0) done_k = k;
         if (bus.mem_req) req_cnt++;
         if (k == 1) begin
            snap_req0 = bus.mem_req; snap_we0 = bus.mem_we; snap_addr0 = bus.mem_addr;
            snap_be0 = bus.mem_be; snap_wd0 = bus.mem_wdata;
         end
         if (k == s1) snap_addr1 = bus.mem_addr;
      end
      @(posedge clk); #1;
      cur_k = fin + 1;
      start = 1'b0; bus.mem_ack = 1'b0;
      prev_err = bad || tmo;
      prev_mdr = new_mdr;
   endtask

   initial begin
      bus.mem_ack = 1'b0;
      bus.mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {63'd0, busy}, 64'd0);
      chk("reset done", {63'd0, done}, 64'd0);
      chk("reset err", {63'd0, err}, 64'd0);
      chk("reset mdr", mdr, 64'd0);
      chk("reset mem_req", {63'd0, bus.mem_req}, 64'd0);
      chk("reset mem_addr", {32'd0, bus.mem_addr}, 64'd0);
      chk("reset mem_be", {60'd0, bus.mem_be}, 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // ld, two beats, immediate acks
      run_txn(1'b0, 3'b011, 64'h100, 64'd0, 0, 0, 32'h89ABCDEF, 32'h01234567, 1'b0);
      chk("ld mdr", mdr, 64'h0123456789ABCDEF);
      chk("ld err", {63'd0, err}, 64'd0);
      chk("ld done cycle", 64'(done_k), 64'd4);
      chk("ld addr0", {32'd0, snap_addr0}, 64'h100);
      chk("ld addr1", {32'd0, snap_addr1}, 64'h104);

      // lb / lbu at top byte lane
      run_txn(1'b0, 3'b000, 64'h203, 64'd0, 0, 0, 32'h80FFFFFF, 32'h0, 1'b0);
      chk("lb be", {60'd0, snap_be0}, 64'h8);
      chk("lb mdr", mdr, 64'hFFFFFFFFFFFFFF80);
      run_txn(1'b0, 3'b100, 64'h203, 64'd0, 0, 0, 32'h80FFFFFF, 32'h0, 1'b0);
      chk("lbu mdr", mdr, 64'h80);

      // sh with ack held off three cycles
      run_txn(1'b1, 3'b001, 64'h12, 64'hBEEF, 3, 0, 32'h0, 32'h0, 1'b0);
      chk("sh addr", {32'd0, snap_addr0}, 64'h10);
      chk("sh be", {60'd0, snap_be0}, 64'hC);
      chk("sh wdata", {32'd0, snap_wd0}, 64'hBEEF0000);
      chk("sh we", {63'd0, snap_we0}, 64'd1);
      chk("sh done cycle", 64'(done_k), 64'd5);
      chk("sh mdr kept", mdr, 64'h80);

      // misaligned lw, then illegal funct3
      run_txn(1'b0, 3'b010, 64'h102, 64'd0, 0, 0, 32'h0, 32'h0, 1'b0);
      chk("lw misalign req", {63'd0, snap_req0}, 64'd0);
      chk("lw misalign done cycle", 64'(done_k), 64'd1);
      chk("lw misalign err", {63'd0, err}, 64'd1);
      chk("lw misalign mdr", mdr, 64'h80);
      run_txn(1'b0, 3'b111, 64'h100, 64'd0, 0, 0, 32'h0, 32'h0, 1'b0);
      chk("f3 111 done cycle", 64'(done_k), 64'd1);
      chk("f3 111 err", {63'd0, err}, 64'd1);

      // timeout: no ack at all
      run_txn(1'b0, 3'b010, 64'h40, 64'd0, T, 0, 32'h0, 32'h0, 1'b0);
      chk("timeout req cycles", 64'(req_cnt), 64'd4);
      chk("timeout done cycle", 64'(done_k), 64'd5);
      chk("timeout err", {63'd0, err}, 64'd1);
      chk("timeout mdr", mdr, 64'h80);

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         bit          op;
         bit [2:0]    f3;
         logic [63:0] a;
         int          d0, d1;
         op = $urandom % 2;
         f3 = 3'($urandom);
         a  = {$urandom, $urandom};
         if ($urandom % 4 != 0) begin
            if (f3[1:0] == 2'd3) a[2:0] = 3'd0;
            else if (f3[1:0] == 2'd2) a[1:0] = 2'd0;
            else if (f3[1:0] == 2'd1) a[0] = 1'b0;
         end
         d0 = ($urandom % 6 == 0) ? T + int'($urandom % 2) : int'($urandom % 4);
         d1 = ($urandom % 6 == 0) ? T + int'($urandom % 2) : int'($urandom % 4);
         run_txn(op, f3, a, {$urandom, $urandom}, d0, d1, $urandom, $urandom, 1'($urandom));
      end

      // reset during the second beat of an sd
      chk_on = 1'b0;
      start = 1'b1; DMemOp = 1'b1; funct3 = 3'b011; addr = 64'h300; wdata = 64'h1122334455667788;
      bus.mem_ack = 1'b0;
      @(posedge clk); #1;
      start = 1'b0; bus.mem_ack = 1'b1;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      @(posedge clk); #1;
      chk("sd beat1 req", {63'd0, bus.mem_req}, 64'd1);
      chk("sd beat1 addr", {32'd0, bus.mem_addr}, 64'h304);
      chk("sd beat1 wdata", {32'd0, bus.mem_wdata}, 64'h11223344);
      reset = 1'b0;
      #1;
      chk("async reset req", {63'd0, bus.mem_req}, 64'd0);
      chk("async reset busy", {63'd0, busy}, 64'd0);
      chk("async reset done", {63'd0, done}, 64'd0);
      chk("async reset mdr", mdr, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      prev_err = 1'b0;
      prev_mdr = '0;
      @(posedge clk); #1;
      run_txn(1'b0, 3'b010, 64'h104, 64'd0, 1, 0, 32'h76543210, 32'h0, 1'b0);
      chk("post-reset lw mdr", mdr, 64'h76543210);
      chk("post-reset lw err", {63'd0, err}, 64'd0);
      chk("post-reset lw done cycle", 64'(done_k), 64'd3);

      @(negedge clk);
      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Load/store sequencer directly downstream of the multicycle control FSM's memory-access states.
- Accepts one access request (load or store, any RISC-V width) and runs it over a 32-bit data-memory bus with a req/ack handshake.
- A 64-bit ld/sd takes two bus beats.
- Returns sign/zero-extended load data in a 64-bit MDR, plus a one-cycle done pulse the control FSM waits on before leaving MEM_ACC_LD/MEM_ACC_SD.

Parameters:
- TIMEOUT, 16: max cycles a beat may wait for mem_ack before aborting with err; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  request strobe from control; sampled only in IDLE
- DMemOp  in  1  0 = load, 1 = store; sampled with start
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu; stores use 000-011 only
- addr  in  64  byte address (ALU out register); only bits [31:0] drive the bus
- wdata  in  64  store data (register B)
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse
- err  out  1  set with done on misalign/illegal funct3/timeout; held until next start
- mdr  out  64  loaded data; updated only on successful load completion
- mem_req  out  1  bus request
- mem_we  out  1  bus write enable
- mem_addr  out  32  word-aligned bus address ([1:0] = 00)
- mem_be  out  4  byte enables
- mem_wdata  out  32  bus write data, lane-aligned
- mem_rdata  in  32  bus read data, valid when mem_ack = 1
- mem_ack  in  1  beat complete

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Reset is asynchronous. Asserting it mid-access drops mem_req in the same instant and returns to IDLE. No done is produced for the aborted access.
- States: IDLE, BEAT0, BEAT1, FIN.
- IDLE: on start=1, capture DMemOp, funct3, addr, wdata.
  - Illegal funct3 is 111, or a store with funct3[2]=1. Misaligned is h with addr[0]≠0, w with addr[1:0]≠0, or d with addr[2:0]≠0.
  - Illegal or misaligned: go to FIN with err pending; no bus activity.
  - Otherwise: go to BEAT0, busy=1.
- busy is 1 in BEAT0, BEAT1 and FIN, and 0 in IDLE.
- BEAT0: mem_req=1, mem_we=DMemOp, mem_addr={addr[31:2],2'b00}.
  - mem_be for b/bu: 0001<<addr[1:0]. For h/hu: 0011<<addr[1:0]. For w/wu/d: 1111.
  - mem_wdata = wdata[31:0] shifted left by 8*addr[1:0].
  - All bus outputs stay stable until mem_ack=1. mem_ack may arrive in the first req cycle.
  - On ack: a load captures mem_rdata. For d go to BEAT1, otherwise go to FIN.
- BEAT1 (d only): mem_addr = BEAT0 address + 4, mem_be=1111, mem_wdata=wdata[63:32]. On ack, capture the upper word and go to FIN.
- mem_req deasserts in the cycle after each ack. There is always at least one cycle with mem_req=0 between BEAT0 and BEAT1.
- FIN: done=1 for exactly one cycle, then IDLE.
  - mdr updates on the FIN edge for successful loads only. Stores and errors leave mdr unchanged.
- Load extraction:
  - Byte: the lane selected by addr[1:0]. Half: bytes addr[1:0]+1..addr[1:0].
  - b/h/w sign-extend to 64 bits; bu/hu/wu zero-extend. d = {beat1, beat0}.
- Latency: start edge → BEAT0. An ack in the first req cycle gives done 2 cycles after start for single-beat accesses and 4 for d. An error with no bus activity gives done 1 cycle after start.
- Timeout: the counter resets at each beat entry and increments while mem_req=1 and mem_ack=0. When it reaches TIMEOUT, abort the beat (mem_req→0), go to FIN with err=1 and leave mdr unchanged. The second beat of a store may thus have been skipped.
- start while busy=1 is ignored (no queueing). start in the same cycle as done is also ignored.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Load ld, addr=0x100, funct3=011, ack immediate; rdata 0x89ABCDEF then 0x01234567 → mem_addr 0x100 then 0x104, done at cycle 4, mdr=0x0123456789ABCDEF, err=0.
- Load lb, addr=0x203, rdata=0x80FFFFFF → mem_be=1000, mdr=0xFFFFFFFFFFFFFF80. Repeat with lbu → mdr=0x80.
- Store sh, addr=0x12, wdata=0xBEEF → mem_addr=0x10, mem_be=1100, mem_wdata=0xBEEF0000, mem_we=1. Ack delayed 3 cycles → bus outputs stable throughout; done one cycle after ack.
- Load lw, addr=0x102 → no mem_req, done 1 cycle after start, err=1, mdr unchanged. funct3=111 → same result.
- TIMEOUT=4, mem_ack never asserted → mem_req high 4 cycles, then done=1, err=1, busy→0.
- Reset pulled low during BEAT1 of an sd → mem_req=0 and busy=0 immediately; after release, a new lw completes normally.
